// File: rtl/ioports_pkg.sv
// Shared definitions for the I/O port host arbiter: op codes, command-byte
// builder and the controller state encoding.
package ioports_pkg;

    localparam logic [1:0] OP_ILLEGAL = 2'b00;
    localparam logic [1:0] OP_RESET   = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_WB3,
        ST_WB2,
        ST_WB1,
        ST_WB0,
        ST_RD_WAIT,
        ST_RD_REL,
        ST_DONE,
        ST_GAP
    } state_t;

    function automatic logic [7:0] cmd_byte(input logic [1:0] op, input logic [3:0] addr);
        return {2'b00, op, addr};
    endfunction

endpackage

// File: rtl/ioports_rr_arb2.sv
// Two-input round-robin arbiter; the last-grant pointer advances only when
// the controller accepts the grant.
module ioports_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant_valid,
    output logic       grant_idx
);

    logic last_grant;

    // On contention the requester not served last wins.
    always_comb begin
        grant_valid = |req;
        if (req == 2'b11)
            grant_idx = ~last_grant;
        else
            grant_idx = req[1];
    end

    // Reset to 1 so that requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b1;
        else if (update && grant_valid)
            last_grant <= grant_idx;
    end

endmodule

// File: rtl/ioports_host_arb.sv
// Two-requester transaction controller serializing RESET/WRITE/READ onto the
// byte-serial command bus of the 32-bit I/O port block.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | sample requests, grant round-robin, latch op/addr/wdata
// CMD        | emit command byte
// WB3..WB0   | emit write data bytes, MS byte first
// RD_WAIT    | io_ready high, wait for io_enout, capture io_dout
// RD_REL     | io_ready low, wait for io_enout to drop; loop for 4 bytes
// DONE       | pulse ack to granted requester, err / rdata valid
// GAP        | idle spacing of GAP_CYCLES cycles before next grant
module ioports_host_arb
    import ioports_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    input  logic [1:0][1:0]  req_op,
    input  logic [1:0][3:0]  req_addr,
    input  logic [1:0][31:0] req_wdata,
    output logic [1:0]       ack,
    output logic             err,
    output logic [31:0]      rdata,
    output logic             io_load,
    output logic [7:0]       io_data,
    output logic             io_ready,
    input  logic             io_enout,
    input  logic [7:0]       io_dout
);

    localparam int GW = $clog2(GAP_CYCLES + 1);

    state_t        state;
    logic          gnt;
    logic [1:0]    op_q;
    logic [3:0]    addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rd_shift;
    logic [1:0]    bcnt;
    logic [GW-1:0] gap_cnt;

    logic          grant_valid;
    logic          grant_idx;
    logic          arb_update;

    assign arb_update = (state == ST_IDLE);

    ioports_rr_arb2 u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (req_valid),
        .update      (arb_update),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Outputs are registered: each state sets the value that appears on the
    // bus in the cycle after it, so the command byte lands one cycle after grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            gnt      <= 1'b0;
            op_q     <= OP_ILLEGAL;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_shift <= '0;
            bcnt     <= '0;
            gap_cnt  <= '0;
            io_load  <= 1'b0;
            io_data  <= '0;
            io_ready <= 1'b0;
            ack      <= '0;
            err      <= 1'b0;
            rdata    <= '0;
        end else begin
            io_load  <= 1'b0;
            io_data  <= '0;
            io_ready <= 1'b0;
            ack      <= '0;
            err      <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        gnt     <= grant_idx;
                        op_q    <= req_op[grant_idx];
                        addr_q  <= req_addr[grant_idx];
                        wdata_q <= req_wdata[grant_idx];
                        bcnt    <= '0;
                        state   <= (req_op[grant_idx] == OP_ILLEGAL) ? ST_DONE : ST_CMD;
                    end
                end
                ST_CMD: begin
                    io_load <= 1'b1;
                    io_data <= cmd_byte(op_q, addr_q);
                    case (op_q)
                        OP_RESET: state <= ST_DONE;
                        OP_WRITE: state <= ST_WB3;
                        default:  state <= ST_RD_WAIT;
                    endcase
                end
                ST_WB3: begin
                    io_load <= 1'b1;
                    io_data <= wdata_q[31:24];
                    state   <= ST_WB2;
                end
                ST_WB2: begin
                    io_load <= 1'b1;
                    io_data <= wdata_q[23:16];
                    state   <= ST_WB1;
                end
                ST_WB1: begin
                    io_load <= 1'b1;
                    io_data <= wdata_q[15:8];
                    state   <= ST_WB0;
                end
                ST_WB0: begin
                    io_load <= 1'b1;
                    io_data <= wdata_q[7:0];
                    state   <= ST_DONE;
                end
                ST_RD_WAIT: begin
                    if (io_enout) begin
                        rd_shift <= {rd_shift[23:0], io_dout};
                        state    <= ST_RD_REL;
                    end else begin
                        io_ready <= 1'b1;
                    end
                end
                ST_RD_REL: begin
                    if (!io_enout) begin
                        if (bcnt == 2'd3) begin
                            state <= ST_DONE;
                        end else begin
                            bcnt  <= bcnt + 2'd1;
                            state <= ST_RD_WAIT;
                        end
                    end
                end
                ST_DONE: begin
                    ack     <= gnt ? 2'b10 : 2'b01;
                    err     <= (op_q == OP_ILLEGAL);
                    if (op_q == OP_READ)
                        rdata <= rd_shift;
                    gap_cnt <= GW'(GAP_CYCLES - 1);
                    state   <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_cnt == '0)
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ioports_host_arb.sv
// Scoreboard bench for ioports_host_arb: expected bus bytes and acks are queued
// by the stimulus and checked by independent monitors; a port model serves reads.
module tb_ioports_host_arb;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       req_valid = '0;
    logic [1:0][1:0]  req_op = '0;
    logic [1:0][3:0]  req_addr = '0;
    logic [1:0][31:0] req_wdata = '0;
    logic [1:0]       ack;
    logic             err;
    logic [31:0]      rdata;
    logic             io_load;
    logic [7:0]       io_data;
    logic             io_ready;
    logic             io_enout = 1'b0;
    logic [7:0]       io_dout = '0;

    ioports_host_arb #(.GAP_CYCLES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .io_load   (io_load),
        .io_data   (io_data),
        .io_ready  (io_ready),
        .io_enout  (io_enout),
        .io_dout   (io_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       is_cmd;
    } bexp_t;

    typedef struct {
        int          who;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } texp_t;

    bexp_t      bq[$];
    texp_t      tq[$];
    logic [7:0] rdq[$];
    bexp_t      be;
    texp_t      te;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ref_cyc = 0;
    int last_ack_cyc = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus monitor: every io_load byte must match the next queued byte.
    always @(negedge clk) begin
        if (io_load) begin
            if (bq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_load: got %0h expected no load (cycle %0d)", io_data, cyc);
            end else begin
                be = bq.pop_front();
                chk("io_data", 32'(io_data), 32'(be.data));
                if (be.is_cmd) begin
                    chk("cmd_gap_after_ack", 32'(cyc - last_ack_cyc >= 3), 32'd1);
                    ref_cyc = cyc;
                end
            end
        end else begin
            chk("io_data_idle_zero", 32'(io_data), 32'd0);
        end
    end

    // Ack monitor: pops the expected completion for every ack pulse.
    always @(negedge clk) begin
        if (ack != 2'b00) begin
            if (tq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got %0b expected none (cycle %0d)", ack, cyc);
            end else begin
                te = tq.pop_front();
                chk("ack_who", 32'(ack), (te.who == 1) ? 32'd2 : 32'd1);
                chk("err", 32'(err), 32'(te.err));
                chk("rdata", rdata, te.rdata);
                if (te.lat >= 0)
                    chk("ack_latency", 32'(cyc - ref_cyc), 32'(te.lat));
            end
            last_ack_cyc = cyc;
        end else begin
            chk("err_without_ack", 32'(err), 32'd0);
        end
    end

    // Port block read model: raise enout when ready, drop it once ready falls.
    always @(negedge clk) begin
        if (reset) begin
            io_enout = 1'b0;
            io_dout  = '0;
        end else if (io_enout) begin
            chk("ready_fall_after_enout", 32'(io_ready), 32'd0);
            io_enout = 1'b0;
            io_dout  = '0;
            ref_cyc  = cyc;
        end else if (io_ready && rdq.size() > 0) begin
            io_enout = 1'b1;
            io_dout  = rdq.pop_front();
        end
    end

    task automatic do_txn(input int who, input logic [1:0] op, input logic [3:0] addr,
                          input logic [31:0] wd);
        bit got;
        got = 1'b0;
        req_op[who]    = op;
        req_addr[who]  = addr;
        req_wdata[who] = wd;
        req_valid[who] = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (ack[who]) got = 1'b1;
        end
        req_valid[who] = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL txn_timeout: got no ack expected ack[%0d]", who);
        end
    endtask

    task automatic push_write(input logic [3:0] addr, input logic [31:0] wd);
        bq.push_back('{8'h20 | 8'(addr), 1'b1});
        bq.push_back('{wd[31:24], 1'b0});
        bq.push_back('{wd[23:16], 1'b0});
        bq.push_back('{wd[15:8], 1'b0});
        bq.push_back('{wd[7:0], 1'b0});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_io_load"}, 32'(io_load), 32'd0);
        chk({tag, "_io_data"}, 32'(io_data), 32'd0);
        chk({tag, "_io_ready"}, 32'(io_ready), 32'd0);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
    endtask

    initial begin
        int n;
        bit seen;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        // Write from requester 0: cmd 0x23 then DE AD BE EF, ack 5 cycles after cmd.
        bq.push_back('{8'h23, 1'b1});
        bq.push_back('{8'hDE, 1'b0});
        bq.push_back('{8'hAD, 1'b0});
        bq.push_back('{8'hBE, 1'b0});
        bq.push_back('{8'hEF, 1'b0});
        tq.push_back('{0, 1'b0, 32'h0, 5});
        do_txn(0, 2'b10, 4'd3, 32'hDEADBEEF);

        // Read from requester 1, address 15; ack 2 bench cycles after last enout drop.
        bq.push_back('{8'h3F, 1'b1});
        rdq.push_back(8'h20);
        rdq.push_back(8'h19);
        rdq.push_back(8'h20);
        rdq.push_back(8'h20);
        tq.push_back('{1, 1'b0, 32'h20192020, 2});
        do_txn(1, 2'b11, 4'd15, 32'h0);

        // Continuous contention: grants must alternate 0,1,0,1.
        push_write(4'd1, 32'hA1A2A3A4);
        push_write(4'd2, 32'hB1B2B3B4);
        push_write(4'd1, 32'hA1A2A3A4);
        push_write(4'd2, 32'hB1B2B3B4);
        tq.push_back('{0, 1'b0, 32'h20192020, 5});
        tq.push_back('{1, 1'b0, 32'h20192020, 5});
        tq.push_back('{0, 1'b0, 32'h20192020, 5});
        tq.push_back('{1, 1'b0, 32'h20192020, 5});
        req_op[0] = 2'b10; req_addr[0] = 4'd1; req_wdata[0] = 32'hA1A2A3A4;
        req_op[1] = 2'b10; req_addr[1] = 4'd2; req_wdata[1] = 32'hB1B2B3B4;
        req_valid = 2'b11;
        n = 0;
        for (int i = 0; i < 500 && n < 4; i++) begin
            @(negedge clk);
            if (ack != 2'b00) n++;
        end
        req_valid = 2'b00;
        chk("alternating_ack_count", 32'(n), 32'd4);

        // Illegal op: no bus activity, err with ack, rdata unchanged.
        tq.push_back('{0, 1'b1, 32'h20192020, -1});
        do_txn(0, 2'b00, 4'd4, 32'h0);

        // Reset while the write is in WB2: no ack, all outputs cleared.
        bq.push_back('{8'h25, 1'b1});
        bq.push_back('{8'h11, 1'b0});
        req_op[0] = 2'b10; req_addr[0] = 4'd5; req_wdata[0] = 32'h11223344;
        req_valid[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (io_load && io_data == 8'h25) seen = 1'b1;
        end
        chk("abort_cmd_seen", 32'(seen), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        chk_all_zero("abort");
        reset = 1'b0;

        // RESET op after abort: cmd 0x10, ack one cycle after the command byte.
        bq.push_back('{8'h10, 1'b1});
        tq.push_back('{1, 1'b0, 32'h0, 1});
        do_txn(1, 2'b01, 4'd0, 32'h0);

        repeat (10) @(negedge clk);
        chk("bytes_left", 32'(bq.size()), 32'd0);
        chk("acks_left", 32'(tq.size()), 32'd0);
        chk("read_bytes_left", 32'(rdq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
